// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle main control FSM.
// Optional feature macro: MC_ADDI_EN adds the addi states AEX/AWB.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_JMRD   = 4'd8,
        S_JMWB   = 4'd9,
        S_BEQ    = 4'd10,
`ifdef MC_ADDI_EN
        S_JMP    = 4'd11,
        S_AEX    = 4'd12,
        S_AWB    = 4'd13
`else
        S_JMP    = 4'd11
`endif
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_JMADD = 6'b110010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_MDR    = 2'b11;

    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC     = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] memtoreg;
        logic [1:0] pcsource;
        logic [1:0] aluop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       regdst;
        logic       regwrite;
    } ctrl_t;

endpackage

// File: rtl/mc_control_if.sv
// Instruction/handshake inputs and datapath control outputs of mc_control.
interface mc_control_if #(
    parameter int OP_W = 6,
    parameter int FN_W = 6
);
    logic [OP_W-1:0] op;
    logic [FN_W-1:0] funct;
    logic            zero;
    logic            mem_ready;
    logic            pcwrite;
    logic            pcwritecond;
    logic            iord;
    logic            memread;
    logic            memwrite;
    logic            irwrite;
    logic [1:0]      memtoreg;
    logic [1:0]      pcsource;
    logic            aluop1;
    logic            aluop0;
    logic            alusrca;
    logic [1:0]      alusrcb;
    logic            regdst;
    logic            regwrite;
    logic            illegal;

    modport master (
        input  op, funct, zero, mem_ready,
        output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, pcsource, aluop1, aluop0, alusrca, alusrcb,
               regdst, regwrite, illegal
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, pcsource, aluop1, aluop0, alusrca, alusrcb,
               regdst, regwrite, illegal
    );
endinterface

// File: rtl/mc_outdec.sv
// Moore state-to-control decode; FETCH qualifies irwrite/pcwrite with mem_ready.
// Optional feature macro: MC_ADDI_EN.
module mc_outdec
    import mc_pkg::*;
(
    input  state_e state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
            end
            S_DECODE: ctrl.alusrcb = SRCB_IMMSH;
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD, S_JMRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = MTR_MDR;
            end
            S_MEMWR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_REX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALUOP_RTYPE;
            end
            S_RWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
                ctrl.memtoreg = MTR_ALUOUT;
            end
            // rd takes the old PC (already PC+4) while PC loads MDR in the same cycle
            S_JMWB: begin
                ctrl.pcwrite  = 1'b1;
                ctrl.pcsource = PCSRC_MDR;
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
                ctrl.memtoreg = MTR_PC;
            end
            S_BEQ: begin
                ctrl.alusrca     = 1'b1;
                ctrl.alusrcb     = SRCB_B;
                ctrl.aluop       = ALUOP_SUB;
                ctrl.pcwritecond = 1'b1;
                ctrl.pcsource    = PCSRC_ALUOUT;
            end
            S_JMP: begin
                ctrl.pcwrite  = 1'b1;
                ctrl.pcsource = PCSRC_JUMP;
            end
`ifdef MC_ADDI_EN
            S_AEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_AWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = MTR_ALUOUT;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle main control FSM feeding the ALU control decoder.
// Optional feature macro: MC_ADDI_EN (addi via AEX/AWB).
module mc_control
    import mc_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int FN_W = 6
) (
    input logic          clk,
    input logic          reset,
    mc_control_if.master bus
);

    state_e state_q, state_d;
    logic   is_sw_q, is_sw_d;
    logic   illegal_c;
    ctrl_t  ctrl_c, ctrl_o;

    // The ALU flag is consumed by the datapath's PC-write gating, not here.
    logic unused_zero;
    assign unused_zero = bus.zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_sw_q <= is_sw_d;
        end
    end

    // op is only looked at in DECODE, so lw/sw is remembered for MEMADR.
    always_comb begin
        state_d   = state_q;
        is_sw_d   = is_sw_q;
        illegal_c = 1'b0;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW: begin
                        state_d = S_MEMADR;
                        is_sw_d = 1'b0;
                    end
                    OP_SW: begin
                        state_d = S_MEMADR;
                        is_sw_d = 1'b1;
                    end
                    OP_RTYPE: state_d = S_REX;
                    OP_BEQ:   state_d = S_BEQ;
                    OP_J:     state_d = S_JMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:  state_d = S_AEX;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_REX:    state_d = (bus.funct == FN_JMADD) ? S_JMRD : S_RWB;
            S_JMRD:   if (bus.mem_ready) state_d = S_JMWB;
`ifdef MC_ADDI_EN
            S_AEX:    state_d = S_AWB;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    mc_outdec u_outdec (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl_c)
    );

    // Reset forces every output low without waiting for a clock edge.
    assign ctrl_o = reset ? '0 : ctrl_c;

    assign bus.pcwrite     = ctrl_o.pcwrite;
    assign bus.pcwritecond = ctrl_o.pcwritecond;
    assign bus.iord        = ctrl_o.iord;
    assign bus.memread     = ctrl_o.memread;
    assign bus.memwrite    = ctrl_o.memwrite;
    assign bus.irwrite     = ctrl_o.irwrite;
    assign bus.memtoreg    = ctrl_o.memtoreg;
    assign bus.pcsource    = ctrl_o.pcsource;
    assign bus.aluop1      = ctrl_o.aluop[1];
    assign bus.aluop0      = ctrl_o.aluop[0];
    assign bus.alusrca     = ctrl_o.alusrca;
    assign bus.alusrcb     = ctrl_o.alusrcb;
    assign bus.regdst      = ctrl_o.regdst;
    assign bus.regwrite    = ctrl_o.regwrite;
    assign bus.illegal     = illegal_c & ~reset;

endmodule

// File: tb/tb_mc_control.sv
// Directed-vector bench for mc_control; expected outputs are hand-built per state.
module tb_mc_control;
    import mc_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mc_control_if #(.OP_W(6), .FN_W(6)) bus ();

    mc_control #(.OP_W(6), .FN_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,pcsource,aluop1,aluop0,alusrca,alusrcb,regdst,regwrite,illegal}
    wire [17:0] outs = {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
                        bus.irwrite, bus.memtoreg, bus.pcsource, bus.aluop1, bus.aluop0,
                        bus.alusrca, bus.alusrcb, bus.regdst, bus.regwrite, bus.illegal};

    localparam logic [17:0] E_ZERO  = 18'b0;
    localparam logic [17:0] E_FW    = 18'b0_0_0_1_0_0_00_00_0_0_0_01_0_0_0;
    localparam logic [17:0] E_FR    = 18'b1_0_0_1_0_1_00_00_0_0_0_01_0_0_0;
    localparam logic [17:0] E_DEC   = 18'b0_0_0_0_0_0_00_00_0_0_0_11_0_0_0;
    localparam logic [17:0] E_DILL  = 18'b0_0_0_0_0_0_00_00_0_0_0_11_0_0_1;
    localparam logic [17:0] E_MADR  = 18'b0_0_0_0_0_0_00_00_0_0_1_10_0_0_0;
    localparam logic [17:0] E_MRD   = 18'b0_0_1_1_0_0_00_00_0_0_0_00_0_0_0;
    localparam logic [17:0] E_MWB   = 18'b0_0_0_0_0_0_01_00_0_0_0_00_0_1_0;
    localparam logic [17:0] E_MWR   = 18'b0_0_1_0_1_0_00_00_0_0_0_00_0_0_0;
    localparam logic [17:0] E_REX   = 18'b0_0_0_0_0_0_00_00_1_0_1_00_0_0_0;
    localparam logic [17:0] E_RWB   = 18'b0_0_0_0_0_0_00_00_0_0_0_00_1_1_0;
    localparam logic [17:0] E_JMWB  = 18'b1_0_0_0_0_0_10_11_0_0_0_00_1_1_0;
    localparam logic [17:0] E_BEQ   = 18'b0_1_0_0_0_0_00_01_0_1_1_00_0_0_0;
    localparam logic [17:0] E_JMP   = 18'b1_0_0_0_0_0_00_10_0_0_0_00_0_0_0;
    localparam logic [17:0] E_AWB   = 18'b0_0_0_0_0_0_00_00_0_0_0_00_0_1_0;

    typedef struct packed {
        logic        mr;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [17:0] exp;
    } vec_t;

    task automatic test_reset();
        vec_t s [4];
        @(negedge clk);
        n_checks++;
        if (outs !== E_ZERO) begin
            n_fail++; $display("FAIL reset_hold: outs=%b required=%b", outs, E_ZERO);
        end
        n_checks++;
        if (dut.state_q !== S_FETCH) begin
            n_fail++; $display("FAIL reset_state: state=%0d required=%0d", dut.state_q, S_FETCH);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        s = '{'{1'b1, OP_LW, 6'd0, E_FR}, '{1'b0, OP_LW, 6'd0, E_DEC},
              '{1'b0, OP_LW, 6'd0, E_MADR}, '{1'b0, OP_LW, 6'd0, E_MRD}};
        foreach (s[i]) begin
            bus.mem_ready = s[i].mr; bus.op = s[i].op; bus.funct = s[i].fn;
            @(negedge clk);
            n_checks++;
            if (outs !== s[i].exp) begin
                n_fail++; $display("FAIL reset_pre[%0d]: outs=%b required=%b", i, outs, s[i].exp);
            end
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        // Still in MEMRD with mem_ready=0: abort via reset between edges.
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (outs !== E_ZERO) begin
            n_fail++; $display("FAIL reset_midstall: outs=%b required=%b", outs, E_ZERO);
        end
        n_checks++;
        if (dut.state_q !== S_FETCH) begin
            n_fail++; $display("FAIL reset_midstall_state: state=%0d required=%0d", dut.state_q, S_FETCH);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outs !== E_FW) begin
            n_fail++; $display("FAIL reset_release: outs=%b required=%b", outs, E_FW);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lw_stall();
        vec_t s [11];
        s = '{'{1'b0, OP_LW, 6'd0, E_FW}, '{1'b0, OP_LW, 6'd0, E_FW},
              '{1'b0, OP_LW, 6'd0, E_FW}, '{1'b1, OP_LW, 6'd0, E_FR},
              '{1'b0, OP_LW, 6'd0, E_DEC}, '{1'b1, 6'b111111, 6'd0, E_MADR},
              '{1'b0, OP_SW, 6'd0, E_MRD}, '{1'b0, OP_SW, 6'd0, E_MRD},
              '{1'b0, OP_SW, 6'd0, E_MRD}, '{1'b1, OP_SW, 6'd0, E_MRD},
              '{1'b1, OP_SW, 6'd0, E_MWB}};
        foreach (s[i]) begin
            bus.mem_ready = s[i].mr; bus.op = s[i].op; bus.funct = s[i].fn;
            @(negedge clk);
            n_checks++;
            if (outs !== s[i].exp) begin
                n_fail++; $display("FAIL lw_stall[%0d]: outs=%b required=%b", i, outs, s[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw();
        vec_t s [6];
        s = '{'{1'b1, OP_SW, 6'd0, E_FR}, '{1'b1, OP_SW, 6'd0, E_DEC},
              '{1'b0, OP_LW, 6'd0, E_MADR}, '{1'b0, OP_LW, 6'd0, E_MWR},
              '{1'b1, OP_LW, 6'd0, E_MWR}, '{1'b0, OP_LW, 6'd0, E_FW}};
        foreach (s[i]) begin
            bus.mem_ready = s[i].mr; bus.op = s[i].op; bus.funct = s[i].fn;
            @(negedge clk);
            n_checks++;
            if (outs !== s[i].exp) begin
                n_fail++; $display("FAIL sw[%0d]: outs=%b required=%b", i, outs, s[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        vec_t s [5];
        s = '{'{1'b1, OP_RTYPE, 6'b100000, E_FR}, '{1'b1, OP_RTYPE, 6'b100000, E_DEC},
              '{1'b1, OP_RTYPE, 6'b100000, E_REX}, '{1'b1, OP_LW, 6'b110010, E_RWB},
              '{1'b0, OP_RTYPE, 6'b100000, E_FW}};
        foreach (s[i]) begin
            bus.mem_ready = s[i].mr; bus.op = s[i].op; bus.funct = s[i].fn;
            @(negedge clk);
            n_checks++;
            if (outs !== s[i].exp) begin
                n_fail++; $display("FAIL rtype[%0d]: outs=%b required=%b", i, outs, s[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jmadd();
        vec_t s [7];
        s = '{'{1'b1, OP_RTYPE, FN_JMADD, E_FR}, '{1'b1, OP_RTYPE, FN_JMADD, E_DEC},
              '{1'b1, OP_RTYPE, FN_JMADD, E_REX}, '{1'b0, OP_RTYPE, 6'b100000, E_MRD},
              '{1'b1, OP_RTYPE, 6'b100000, E_MRD}, '{1'b1, OP_RTYPE, 6'b100000, E_JMWB},
              '{1'b0, OP_RTYPE, 6'b100000, E_FW}};
        foreach (s[i]) begin
            bus.mem_ready = s[i].mr; bus.op = s[i].op; bus.funct = s[i].fn;
            @(negedge clk);
            n_checks++;
            if (outs !== s[i].exp) begin
                n_fail++; $display("FAIL jmadd[%0d]: outs=%b required=%b", i, outs, s[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        vec_t s [8];
        s = '{'{1'b1, OP_BEQ, 6'd0, E_FR}, '{1'b1, OP_BEQ, 6'd0, E_DEC},
              '{1'b1, OP_BEQ, 6'd0, E_BEQ}, '{1'b0, OP_J, 6'd0, E_FW},
              '{1'b1, OP_J, 6'd0, E_FR}, '{1'b0, OP_J, 6'd0, E_DEC},
              '{1'b1, OP_J, 6'd0, E_JMP}, '{1'b0, OP_J, 6'd0, E_FW}};
        bus.zero = 1'b1;
        foreach (s[i]) begin
            bus.mem_ready = s[i].mr; bus.op = s[i].op; bus.funct = s[i].fn;
            @(negedge clk);
            n_checks++;
            if (outs !== s[i].exp) begin
                n_fail++; $display("FAIL branch_jump[%0d]: outs=%b required=%b", i, outs, s[i].exp);
            end
            @(posedge clk); #1;
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_illegal();
        vec_t s [4];
        s = '{'{1'b1, 6'b111111, 6'd0, E_FR}, '{1'b1, 6'b111111, 6'd0, E_DILL},
              '{1'b0, 6'b111111, 6'd0, E_FW}, '{1'b0, 6'b111111, 6'd0, E_FW}};
        foreach (s[i]) begin
            bus.mem_ready = s[i].mr; bus.op = s[i].op; bus.funct = s[i].fn;
            @(negedge clk);
            n_checks++;
            if (outs !== s[i].exp) begin
                n_fail++; $display("FAIL illegal[%0d]: outs=%b required=%b", i, outs, s[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addi();
`ifdef MC_ADDI_EN
        vec_t s [5];
        s = '{'{1'b1, OP_ADDI, 6'd0, E_FR}, '{1'b1, OP_ADDI, 6'd0, E_DEC},
              '{1'b1, OP_ADDI, 6'd0, E_MADR}, '{1'b1, OP_ADDI, 6'd0, E_AWB},
              '{1'b0, OP_ADDI, 6'd0, E_FW}};
`else
        vec_t s [3];
        s = '{'{1'b1, OP_ADDI, 6'd0, E_FR}, '{1'b1, OP_ADDI, 6'd0, E_DILL},
              '{1'b0, OP_ADDI, 6'd0, E_FW}};
`endif
        foreach (s[i]) begin
            bus.mem_ready = s[i].mr; bus.op = s[i].op; bus.funct = s[i].fn;
            @(negedge clk);
            n_checks++;
            if (outs !== s[i].exp) begin
                n_fail++; $display("FAIL addi[%0d]: outs=%b required=%b", i, outs, s[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus.op        = 6'd0;
        bus.funct     = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_lw_stall();
        test_sw();
        test_rtype();
        test_jmadd();
        test_branch_jump();
        test_illegal();
        test_addi();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle main control FSM that sits directly upstream of the ALU control decoder.
- Decodes the 6-bit opcode and the function field. Drives the datapath enables, and drives aluop1/aluop0, which the ALU control decoder consumes.
- Supports R-type (including the custom jmadd), lw, sw, beq and j.
- Stalls on a memory-ready handshake.

Parameters:
- OP_W, 6, opcode width.
- FN_W, 6, function-field width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  6  instruction register opcode (IR[31:26]).
- funct  in  6  instruction register function field (IR[5:0]).
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory handshake; 1 = the current access completes this cycle.
- pcwrite  out  1  unconditional PC write enable.
- pcwritecond  out  1  PC write enable qualified by zero (beq).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- irwrite  out  1  IR load enable.
- memtoreg  out  2  register writeback select: 00 = ALUOut, 01 = MDR, 10 = PC.
- pcsource  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = MDR.
- aluop1  out  1  ALU operation class, to the ALU control decoder.
- aluop0  out  1  ALU operation class, to the ALU control decoder.
- alusrca  out  1  ALU A select: 0 = PC, 1 = A register.
- alusrcb  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- regdst  out  1  destination select: 0 = rt, 1 = rd.
- regwrite  out  1  register file write enable.
- illegal  out  1  one-cycle pulse on an unknown opcode.

Behaviour:
- Reset is asynchronous and active-high; the FSM uses one clock, clk.
- While reset=1: state = FETCH and every output = 0.
- After reset deasserts, outputs are a Moore decode of state, except the mem_ready-qualified enables listed below.
- Opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, j = 000010.
- jmadd is the R-type with funct = 110010.
- aluop encoding: 00 = add, 01 = subtract (beq), 10 = R-type decode.

States and outputs:
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
  - irwrite and pcwrite are asserted only when mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target to ALUOut).
  - lw or sw -> MEMADR.
  - R -> REX.
  - beq -> BEQ.
  - j -> JMP.
  - Any other opcode -> FETCH, with illegal=1 for this cycle.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD: memread=1, iord=1. Holds until mem_ready=1, then -> MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=01. -> FETCH.
- MEMWR: memwrite=1, iord=1. Holds until mem_ready=1, then -> FETCH.
- REX: alusrca=1, alusrcb=00, aluop=10. -> JMRD if funct=110010, else RWB.
- RWB: regwrite=1, regdst=1, memtoreg=00. -> FETCH.
- JMRD: memread=1, iord=1. Reads mem[rs+rt]. Holds until mem_ready=1, then -> JMWB.
- JMWB: pcwrite=1, pcsource=11, regwrite=1, regdst=1, memtoreg=10.
  - Writes rd <= PC (already PC+4) and PC <= MDR.
  - Both writes occur in the same cycle. The register file samples the old PC, so the ordering is safe.
  - -> FETCH.
- BEQ: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01. -> FETCH.
  - The datapath, not this FSM, gates the PC write with zero.
- JMP: pcwrite=1, pcsource=10. -> FETCH.

Rules and boundary cases:
- pcwrite and pcwritecond are never both 1 in the same cycle.
- memread and memwrite are never both 1 in the same cycle.
- mem_ready is ignored in every state other than the wait states (FETCH, MEMRD, MEMWR, JMRD).
- A reset mid-stall aborts the access; any write enable already asserted drops immediately.
- op and funct are sampled only in DECODE and REX. Changes to them elsewhere have no effect.

Optional Feature:
- Macro: MC_ADDI_EN.
- Defined: opcode 001000 (addi) decodes in DECODE to AEX, then AWB, then FETCH.
  - AEX: alusrca=1, alusrcb=10, aluop=00.
  - AWB: regwrite=1, regdst=0, memtoreg=00.
- Undefined: 001000 is illegal (illegal pulse, return to FETCH), and states AEX/AWB do not exist.

Decomposition:
- Package mc_pkg holds:
  - the state enum (4-bit);
  - opcode constants;
  - the JMADD funct constant;
  - the aluop, pcsource, memtoreg and alusrcb encodings.
- One sub-module, mc_outdec: purely combinational state-to-outputs decode, with a mem_ready input for the qualified enables.
- The next-state logic stays in mc_control.

Test Plan:
- Reset: assert reset mid-MEMRD with mem_ready=0 -> all outputs 0 immediately; after release, state=FETCH and memread=1.
- lw with mem_ready held 0 for 3 cycles in FETCH and in MEMRD:
  - FETCH lasts 4 cycles, with irwrite=1 only on the 4th.
  - Full sequence is FETCH, DECODE, MEMADR, MEMRD(x4), MEMWB; regwrite=1 with memtoreg=01 in MEMWB.
- R-type add (funct 100000) -> aluop=10 in REX; in RWB, regwrite=1 and regdst=1; total 4 cycles with mem_ready=1.
- jmadd (funct 110010) -> REX, JMRD, JMWB; in JMWB, pcwrite=1, pcsource=11, memtoreg=10, regwrite=1.
- beq -> BEQ state with aluop=01, pcwritecond=1, pcsource=01; j -> pcwrite=1, pcsource=10.
- op=111111 -> illegal=1 for exactly 1 cycle, then FETCH.
  - Repeat with op=001000 under MC_ADDI_EN: no illegal pulse, and AWB asserts regwrite=1 with regdst=0.
